// File: rtl/axi_lite_pkg.sv
// Shared response codes and FSM encodings
// for the AXI4-Lite slave bridge.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DO,
      W_RESP
   } wr_state_t;

endpackage

// File: rtl/axi_lite_slave_ctrl_if.sv
// AXI4-Lite bus bundle between the core
// master and the slave bridge.
interface axi_lite_slave_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport slave (
      input  araddr, arvalid, rready,
      input  awaddr, awvalid,
      input  wdata, wstrb, wvalid,
      input  bready,
      output arready, rdata, rresp, rvalid,
      output awready, wready,
      output bresp, bvalid
   );

   modport master (
      output araddr, arvalid, rready,
      output awaddr, awvalid,
      output wdata, wstrb, wvalid,
      output bready,
      input  arready, rdata, rresp, rvalid,
      input  awready, wready,
      input  bresp, bvalid
   );

endinterface

// File: rtl/lat_counter.sv
// Programmable 8-bit down-counter; zero
// marks the read data-capture cycle.
module lat_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] value,
   output logic       zero
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= 8'd0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != 8'd0) begin
         cnt <= cnt - 8'd1;
      end
   end

   assign zero = (cnt == 8'd0);

endmodule

// File: rtl/axi_lite_slave_ctrl.sv
// AXI4-Lite slave bridge to a synchronous
// memory port; independent read/write FSMs.
module axi_lite_slave_ctrl
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1,
   parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] ADDR_SIZE = 32'h0800_0000
) (
   input  logic                clk,
   input  logic                rst,
   axi_lite_slave_ctrl_if.slave io_slave,
   output logic                need_read,
   output logic [ADDR_W-1:0]   raddr,
   input  logic [DATA_W-1:0]   rdata,
   output logic                need_write,
   output logic [ADDR_W-1:0]   waddr,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb
);

   // One extra bit so BASE+SIZE cannot wrap.
   localparam logic [ADDR_W:0] LO = {1'b0, ADDR_BASE};
   localparam logic [ADDR_W:0] HI = LO + {1'b0, ADDR_SIZE};

   function automatic logic hit(
      input logic [ADDR_W-1:0] a
   );
      logic [ADDR_W:0] x;
      x = {1'b0, a};
      return (x >= LO) && (x < HI);
   endfunction

   rd_state_t rd_state;
   logic      ar_hs;
   logic      lat_load;
   logic      lat_zero;

   assign ar_hs = io_slave.arvalid
                & io_slave.arready;
   assign lat_load = ar_hs
                   & hit(io_slave.araddr);

   lat_counter u_lat (
      .clk   (clk),
      .rst   (rst),
      .load  (lat_load),
      .value (8'(READ_LAT)),
      .zero  (lat_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_state         <= R_IDLE;
         io_slave.arready <= 1'b0;
         io_slave.rvalid  <= 1'b0;
         io_slave.rdata   <= '0;
         io_slave.rresp   <= RESP_OKAY;
         need_read        <= 1'b0;
         raddr            <= '0;
      end else begin
         need_read <= 1'b0;
         unique case (rd_state)
            R_IDLE: begin
               if (ar_hs) begin
                  io_slave.arready <= 1'b0;
                  if (hit(io_slave.araddr)) begin
                     need_read <= 1'b1;
                     raddr     <= io_slave.araddr;
                     rd_state  <= R_WAIT;
                  end else begin
                     io_slave.rvalid <= 1'b1;
                     io_slave.rresp  <= RESP_DECERR;
                     io_slave.rdata  <= '0;
                     rd_state        <= R_RESP;
                  end
               end else begin
                  io_slave.arready <= 1'b1;
               end
            end
            R_WAIT: begin
               if (lat_zero) begin
                  io_slave.rvalid <= 1'b1;
                  io_slave.rresp  <= RESP_OKAY;
                  io_slave.rdata  <= rdata;
                  rd_state        <= R_RESP;
               end
            end
            R_RESP: begin
               if (io_slave.rready) begin
                  io_slave.rvalid  <= 1'b0;
                  io_slave.arready <= 1'b1;
                  rd_state         <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   wr_state_t           wr_state;
   logic                aw_hs;
   logic                w_hs;
   logic                aw_held;
   logic                w_held;
   logic                aw_have;
   logic                w_have;
   logic [ADDR_W-1:0]   aw_q;
   logic [ADDR_W-1:0]   aw_cur;
   logic [DATA_W-1:0]   wd_q;
   logic [DATA_W-1:0]   wd_cur;
   logic [DATA_W/8-1:0] ws_q;
   logic [DATA_W/8-1:0] ws_cur;

   assign aw_hs = io_slave.awvalid
                & io_slave.awready;
   assign w_hs  = io_slave.wvalid
                & io_slave.wready;
   assign aw_have = aw_held | aw_hs;
   assign w_have  = w_held | w_hs;
   // Beats arriving this cycle bypass the holding regs.
   assign aw_cur = aw_hs ? io_slave.awaddr : aw_q;
   assign wd_cur = w_hs ? io_slave.wdata : wd_q;
   assign ws_cur = w_hs ? io_slave.wstrb : ws_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_state         <= W_IDLE;
         io_slave.awready <= 1'b0;
         io_slave.wready  <= 1'b0;
         io_slave.bvalid  <= 1'b0;
         io_slave.bresp   <= RESP_OKAY;
         aw_held          <= 1'b0;
         w_held           <= 1'b0;
         aw_q             <= '0;
         wd_q             <= '0;
         ws_q             <= '0;
         need_write       <= 1'b0;
         waddr            <= '0;
         wdata            <= '0;
         wstrb            <= '0;
      end else begin
         need_write <= 1'b0;
         unique case (wr_state)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_held <= 1'b1;
                  aw_q    <= io_slave.awaddr;
               end
               if (w_hs) begin
                  w_held <= 1'b1;
                  wd_q   <= io_slave.wdata;
                  ws_q   <= io_slave.wstrb;
               end
               io_slave.awready <= !aw_have;
               io_slave.wready  <= !w_have;
               if (aw_have && w_have) begin
                  need_write <= hit(aw_cur);
                  waddr      <= aw_cur;
                  wdata      <= wd_cur;
                  wstrb      <= ws_cur;
                  io_slave.bresp <= hit(aw_cur)
                                  ? RESP_OKAY
                                  : RESP_DECERR;
                  wr_state <= W_DO;
               end
            end
            W_DO: begin
               io_slave.bvalid <= 1'b1;
               wr_state        <= W_RESP;
            end
            W_RESP: begin
               if (io_slave.bready) begin
                  io_slave.bvalid  <= 1'b0;
                  io_slave.awready <= 1'b1;
                  io_slave.wready  <= 1'b1;
                  aw_held          <= 1'b0;
                  w_held           <= 1'b0;
                  wr_state         <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_slave_ctrl.sv
// Scoreboard bench for axi_lite_slave_ctrl
// with a fixed-latency memory model.
module tb_axi_lite_slave_ctrl;

   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   axi_lite_slave_ctrl_if #(
      .ADDR_W(32), .DATA_W(32)
   ) io ();

   logic        need_read;
   logic        need_write;
   logic [31:0] raddr;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [31:0] mem_rdata = 32'hBAD0_BAD0;
   logic [3:0]  wstrb;

   axi_lite_slave_ctrl #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .READ_LAT  (LAT),
      .ADDR_BASE (32'h8000_0000),
      .ADDR_SIZE (32'h0800_0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .io_slave   (io),
      .need_read  (need_read),
      .raddr      (raddr),
      .rdata      (mem_rdata),
      .need_write (need_write),
      .waddr      (waddr),
      .wdata      (wdata),
      .wstrb      (wstrb)
   );

   typedef struct {
      logic [31:0] d;
      logic [1:0]  s;
      int          lat;
   } rexp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;
   } wexp_t;

   rexp_t       exp_r[$];
   logic [31:0] exp_nr[$];
   wexp_t       exp_nw[$];
   logic [1:0]  exp_b[$];

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h required %h",
                  nm, got, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      ntests++;
      nfail++;
      $display("FAIL %s: event seen or timed out",
               nm);
   endtask

   function automatic logic in_win(
      input logic [31:0] a);
      logic [32:0] x;
      x = {1'b0, a};
      return x >= 33'h0_8000_0000 &&
             x <  33'h0_8800_0000;
   endfunction

   function automatic logic [31:0] mem_fn(
      input logic [31:0] a);
      if (a == 32'h8000_0010) return 32'hDEADBEEF;
      return ~a ^ 32'h1357_9BDF;
   endfunction

   // Memory drives data only in cycle T1+LAT.
   int          rd_due = -1;
   logic [31:0] rd_val = '0;
   always @(negedge clk)
      if (need_read) begin
         rd_due = cyc + LAT;
         rd_val = mem_fn(raddr);
      end
   always @(posedge clk) begin
      #1;
      mem_rdata = (cyc == rd_due)
                ? rd_val : 32'hBAD0_BAD0;
   end

   int          ar_c = 0;
   int          r_first = 0;
   int          nr_c = -1;
   bit          r_act = 0;
   bit          r_bad = 0;
   bit          r_post = 0;
   logic [31:0] r_d;
   logic [1:0]  r_s;
   rexp_t       re;
   logic [31:0] ea;

   always @(negedge clk) begin
      if (io.arvalid && io.arready) ar_c = cyc;
      if (need_read) begin
         nr_c = cyc;
         if (exp_nr.size() == 0) begin
            fail_now("need_read_unexpected");
         end else begin
            ea = exp_nr.pop_front();
            chk("raddr", 64'(raddr), 64'(ea));
            chk("need_read_cycle",
                64'(cyc - ar_c), 64'(1));
         end
      end
      if (r_post) begin
         chk("r_after_hs_rvalid_arready",
             64'({io.rvalid, io.arready}),
             64'(2'b01));
         r_post = 0;
      end
      if (io.rvalid) begin
         if (!r_act) begin
            r_act   = 1;
            r_bad   = 0;
            r_first = cyc;
            r_d     = io.rdata;
            r_s     = io.rresp;
         end else if (io.rdata !== r_d ||
                      io.rresp !== r_s) begin
            r_bad = 1;
         end
         if (io.arready) r_bad = 1;
         if (io.rready) begin
            if (exp_r.size() == 0) begin
               fail_now("rvalid_unexpected");
            end else begin
               re = exp_r.pop_front();
               chk("rdata", 64'(io.rdata), 64'(re.d));
               chk("rresp", 64'(io.rresp), 64'(re.s));
               chk("r_latency",
                   64'(r_first - ar_c), 64'(re.lat));
               chk("r_stable", 64'(r_bad), 64'(0));
            end
            r_act  = 0;
            r_post = 1;
         end
      end else if (r_act) begin
         fail_now("rvalid_dropped");
         r_act = 0;
      end
   end

   int    aw_c = 0;
   int    w_c = 0;
   int    b_first = 0;
   int    nw_c = -2;
   bit    b_act = 0;
   bit    b_post = 0;
   wexp_t we;
   logic [1:0] eb;

   function automatic int wmax();
      return (aw_c > w_c) ? aw_c : w_c;
   endfunction

   always @(negedge clk) begin
      if (io.awvalid && io.awready) aw_c = cyc;
      if (io.wvalid && io.wready) w_c = cyc;
      if (need_write) begin
         nw_c = cyc;
         if (exp_nw.size() == 0) begin
            fail_now("need_write_unexpected");
         end else begin
            we = exp_nw.pop_front();
            chk("waddr", 64'(waddr), 64'(we.a));
            chk("wdata", 64'(wdata), 64'(we.d));
            chk("wstrb", 64'(wstrb), 64'(we.m));
            chk("need_write_cycle",
                64'(cyc - wmax()), 64'(1));
         end
      end
      if (b_post) begin
         chk("b_after_hs_bvalid_readies",
             64'({io.bvalid, io.awready, io.wready}),
             64'(3'b011));
         b_post = 0;
      end
      if (io.bvalid) begin
         if (!b_act) begin
            b_act   = 1;
            b_first = cyc;
         end
         if (io.bready) begin
            if (exp_b.size() == 0) begin
               fail_now("bvalid_unexpected");
            end else begin
               eb = exp_b.pop_front();
               chk("bresp", 64'(io.bresp), 64'(eb));
               chk("b_latency",
                   64'(b_first - wmax()), 64'(2));
            end
            b_act  = 0;
            b_post = 1;
         end
      end else if (b_act) begin
         fail_now("bvalid_dropped");
         b_act = 0;
      end
   end

   task automatic rd_expect(input logic [31:0] a);
      if (in_win(a)) begin
         exp_nr.push_back(a);
         exp_r.push_back('{mem_fn(a), 2'b00, LAT + 2});
      end else begin
         exp_r.push_back('{32'h0, 2'b11, 1});
      end
   endtask

   task automatic wr_expect(input logic [31:0] a,
                            input logic [31:0] d,
                            input logic [3:0]  m);
      if (in_win(a)) begin
         exp_nw.push_back('{a, d, m});
         exp_b.push_back(2'b00);
      end else begin
         exp_b.push_back(2'b11);
      end
   endtask

   task automatic ar_send(input logic [31:0] a);
      int n = 0;
      io.araddr  = a;
      io.arvalid = 1'b1;
      @(negedge clk);
      while (!io.arready && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!io.arready) fail_now("ar_timeout");
      @(posedge clk);
      #1 io.arvalid = 1'b0;
   endtask

   task automatic aw_send(input logic [31:0] a);
      int n = 0;
      io.awaddr  = a;
      io.awvalid = 1'b1;
      @(negedge clk);
      while (!io.awready && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!io.awready) fail_now("aw_timeout");
      @(posedge clk);
      #1 io.awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] d,
                         input logic [3:0]  m);
      int n = 0;
      io.wdata  = d;
      io.wstrb  = m;
      io.wvalid = 1'b1;
      @(negedge clk);
      while (!io.wready && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!io.wready) fail_now("w_timeout");
      @(posedge clk);
      #1 io.wvalid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((exp_r.size() != 0 ||
                  exp_b.size() != 0 ||
                  exp_nr.size() != 0 ||
                  exp_nw.size() != 0 ||
                  io.rvalid || io.bvalid) &&
                 n < 100);
      if (n >= 100) fail_now("idle_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input bit is_r);
      int n = 0;
      while (!(is_r ? io.rvalid : io.bvalid) &&
             n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) fail_now("valid_timeout");
   endtask

   task automatic wr_issue(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [3:0]  m);
      wr_expect(a, d, m);
      fork
         aw_send(a);
         w_send(d, m);
      join
      wait_idle();
   endtask

   task automatic rd_issue(input logic [31:0] a);
      rd_expect(a);
      ar_send(a);
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      io.araddr  = '0;
      io.arvalid = 1'b0;
      io.rready  = 1'b1;
      io.awaddr  = '0;
      io.awvalid = 1'b0;
      io.wdata   = '0;
      io.wstrb   = '0;
      io.wvalid  = 1'b0;
      io.bready  = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl",
          64'({io.arready, io.awready, io.wready,
               io.rvalid, io.bvalid,
               need_read, need_write}),
          64'(0));
      chk("reset_data",
          64'({io.rdata | raddr | waddr | wdata,
               io.rresp, io.bresp, wstrb}),
          64'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("readies_after_reset",
          64'({io.arready, io.awready, io.wready}),
          64'(3'b111));
      @(posedge clk);
      #1;

      // latency-3 read
      rd_issue(32'h8000_0010);

      // R back-pressure, 4 stalled cycles
      io.rready = 1'b0;
      rd_expect(32'h8000_0040);
      ar_send(32'h8000_0040);
      wait_valid(1'b1);
      repeat (4) @(posedge clk);
      #1 io.rready = 1'b1;
      wait_idle();

      // W beat two cycles ahead of AW
      wr_expect(32'h8000_0004, 32'h1122_3344, 4'b0101);
      fork
         begin
            w_send(32'h1122_3344, 4'b0101);
            @(negedge clk);
            chk("w_first_ready",
                64'({io.wready, io.awready}),
                64'(2'b01));
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            aw_send(32'h8000_0004);
         end
      join
      wait_idle();

      // decode window and strobe edges
      rd_issue(32'h0000_1000);
      wr_issue(32'h9000_0000, 32'hCAFE_F00D, 4'hF);
      rd_issue(32'h87FF_FFFC);
      rd_issue(32'h7FFF_FFFC);
      wr_issue(32'h8800_0000, 32'h0BAD_CAFE, 4'hF);
      wr_issue(32'h87FF_FFF0, 32'h5555_AAAA, 4'h0);

      // concurrent read + write, B stalled
      io.bready = 1'b0;
      rd_expect(32'h8000_0100);
      wr_expect(32'h8000_0200, 32'hA5A5_0F0F, 4'b1100);
      fork
         ar_send(32'h8000_0100);
         aw_send(32'h8000_0200);
         w_send(32'hA5A5_0F0F, 4'b1100);
      join
      wait_valid(1'b0);
      repeat (3) @(posedge clk);
      #1 io.bready = 1'b1;
      wait_idle();
      chk("need_rd_wr_same_cycle",
          64'(nr_c), 64'(nw_c));

      // reset while the read waits on memory
      exp_nr.push_back(32'h8000_0020);
      ar_send(32'h8000_0020);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_reset_outputs",
          64'({io.rvalid, io.arready, need_read}),
          64'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("arready_after_mid_reset",
          64'(io.arready), 64'(1));
      repeat (LAT + 3) @(negedge clk);
      @(posedge clk);
      #1;
      rd_issue(32'h8000_0030);

      chk("queues_drained",
          64'(exp_r.size() + exp_b.size() +
              exp_nr.size() + exp_nw.size()),
          64'(0));
      $display("[TB] %0d tests run, %0d failed",
               ntests, nfail);
      $finish;
   end

endmodule

// File: doc/axi_lite_slave_ctrl.md
Name: axi_lite_slave_ctrl

Overview:
Parametrised AXI4-Lite slave bridge between the core's AXI master and a simple synchronous memory/peripheral port. Successor to the fixed 32-bit slave: configurable data width, configurable read latency, independent AW/W acceptance, write strobes passed through, address-range decode with DECERR, and full R/B back-pressure. Single-beat transfers only, one outstanding read and one outstanding write. The read and write channels are independent.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (32 or 64); strobe width is DATA_W/8
READ_LAT, 1, memory read latency in cycles (1..255)
ADDR_BASE, 32'h8000_0000, first decoded address
ADDR_SIZE, 32'h0800_0000, decoded window size in bytes; in range iff ADDR_BASE <= addr < ADDR_BASE+ADDR_SIZE

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low (0 = reset)
io_slave_araddr  in  ADDR_W  read address
io_slave_arvalid  in  1  read address valid
io_slave_arready  out  1  read address ready
io_slave_rdata  out  DATA_W  read data
io_slave_rresp  out  2  read response (00 OKAY, 11 DECERR)
io_slave_rvalid  out  1  read data valid
io_slave_rready  in  1  read data ready
io_slave_awaddr  in  ADDR_W  write address
io_slave_awvalid  in  1  write address valid
io_slave_awready  out  1  write address ready
io_slave_wdata  in  DATA_W  write data
io_slave_wstrb  in  DATA_W/8  byte strobes
io_slave_wvalid  in  1  write data valid
io_slave_wready  out  1  write data ready
io_slave_bresp  out  2  write response
io_slave_bvalid  out  1  write response valid
io_slave_bready  in  1  write response ready
need_read  out  1  one-cycle memory read strobe
raddr  out  ADDR_W  memory read address
rdata  in  DATA_W  memory read data
need_write  out  1  one-cycle memory write strobe
waddr  out  ADDR_W  memory write address
wdata  out  DATA_W  memory write data
wstrb  out  DATA_W/8  memory byte enables

Behaviour:
- Reset (rst=0 at posedge): read FSM R_IDLE, write FSM W_IDLE; all valid/strobe outputs 0; rdata/rresp/bresp/raddr/waddr/wdata/wstrb 0; arready/awready/wready 0 during reset, 1 in the first cycle after release. Reset mid-transaction drops it silently, with no need_* pulse afterwards.
- All outputs are registered; no combinational input-to-output paths.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. On AR handshake (cycle T0), latch the address and clear arready.
  - In range: need_read=1 with raddr during T1 only; enter R_WAIT and load the latency counter with READ_LAT.
  - R_WAIT: memory drives rdata during cycle T1+READ_LAT; the slave registers it at the end of that cycle. rvalid=1 and rresp=00 from T0+READ_LAT+2.
  - Out of range: no need_read. rvalid=1, rresp=11, rdata=0 from T1.
  - R_RESP: rvalid, rdata and rresp are held stable until rready=1. On handshake, rvalid drops and the FSM returns to R_IDLE; arready=1 in the next cycle.
- Write FSM states: W_IDLE, W_DO, W_RESP.
  - W_IDLE: awready and wready are each 1 until their own beat is captured, then that ready drops. AW and W may arrive in either order or in the same cycle.
  - When both beats are held, go to W_DO. In range: need_write=1 for exactly one cycle with waddr/wdata/wstrb. Out of range: no need_write.
  - Next state W_RESP: bvalid=1, bresp 00 or 11, held until bready. Then W_IDLE, with both readies 1 in the following cycle.
- wstrb is passed through unmodified, including all-zero; all-zero still pulses need_write.
- Read and write channels are fully concurrent; need_read and need_write may be asserted in the same cycle.
- Range compare uses ADDR_W+1-bit arithmetic, so ADDR_BASE+ADDR_SIZE does not wrap.
- The latency counter is a down-counter; zero means the data-capture cycle.

Decomposition:
- Package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11; read/write FSM state encodings.
- Sub-module lat_counter: load/start, count, zero flag. Generalises the existing COUNT block to an 8-bit programmable load.

Test Plan:
- READ_LAT=3, AR 0x8000_0010 at T0, memory returns 0xDEADBEEF in T4 -> need_read only at T1 with raddr=0x8000_0010; rvalid at T5 with rdata=0xDEADBEEF, rresp=00; arready=1 the cycle after the R handshake.
- rready held low 4 cycles after rvalid -> rvalid, rdata and rresp constant; arready stays 0; handshake in cycle 5 -> rvalid=0 next cycle.
- W (0x1122_3344, wstrb 4'b0101) two cycles before AW 0x8000_0004 -> wready=0 after the W beat while awready stays 1; single need_write with all three values; bresp=00.
- Read 0x0000_1000 and write 0x9000_0000 -> no need_read/need_write; rresp=11 with rdata=0; bresp=11.
- AR and AW+W in the same cycle with bready low 3 cycles -> need_read and need_write both fire; bvalid held 3 cycles; read completes unaffected.
- rst=0 while in R_WAIT -> rvalid stays 0, no need_* pulse; after release, arready=1 and a fresh read completes normally.
